// File: rtl/projetof_scale.sv
// Price-computing scale datapath: splits weight, price per kg and total price
// into whole/fractional parts, all registered with one cycle of latency.
module projetof_scale (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  centimos,
  input  logic [13:0] pesoemgramas,
  output logic [15:0] Peso_Final_unidades,
  output logic [15:0] Peso_Final_decimal,
  output logic [15:0] Preco_Parte_Inteira,
  output logic [15:0] Preco_Parte_Decimal,
  output logic [15:0] Preco_Por_Kg_Parte_Inteira,
  output logic [15:0] Preco_Por_Kg_Parte_Decimal
);

  // No handshake: inputs are sampled on every rising edge of clk and the
  // six outputs are valid from just after that edge until the next one.

  logic [15:0] peso_ext;
  logic [15:0] cent_ext;
  logic [22:0] product;
  logic [13:0] total_cents;
  logic [15:0] total_ext;

  logic [15:0] peso_unid_d;
  logic [15:0] peso_dec_d;
  logic [15:0] kg_int_d;
  logic [15:0] kg_dec_d;
  logic [15:0] total_int_d;
  logic [15:0] total_dec_d;

  // Full 23-bit product so the largest price*weight (8,371,713) never wraps;
  // the quotient by 1000 fits in 14 bits (max 8371).
  always_comb begin
    peso_ext    = 16'(pesoemgramas);
    cent_ext    = 16'(centimos);
    product     = 23'(centimos) * 23'(pesoemgramas);
    total_cents = 14'(product / 23'd1000);
    total_ext   = 16'(total_cents);

    peso_unid_d = peso_ext / 16'd1000;
    peso_dec_d  = peso_ext % 16'd1000;
    kg_int_d    = cent_ext / 16'd100;
    kg_dec_d    = cent_ext % 16'd100;
    total_int_d = total_ext / 16'd100;
    total_dec_d = total_ext % 16'd100;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Peso_Final_unidades        <= '0;
      Peso_Final_decimal         <= '0;
      Preco_Parte_Inteira        <= '0;
      Preco_Parte_Decimal        <= '0;
      Preco_Por_Kg_Parte_Inteira <= '0;
      Preco_Por_Kg_Parte_Decimal <= '0;
    end else begin
      Peso_Final_unidades        <= peso_unid_d;
      Peso_Final_decimal         <= peso_dec_d;
      Preco_Parte_Inteira        <= total_int_d;
      Preco_Parte_Decimal        <= total_dec_d;
      Preco_Por_Kg_Parte_Inteira <= kg_int_d;
      Preco_Por_Kg_Parte_Decimal <= kg_dec_d;
    end
  end

endmodule

// File: tb/tb_projetof_scale.sv
// Directed-vector bench for projetof_scale: reset, table of hand-computed
// cases, and a randomized back-to-back sequence with a mid-stream reset.
module tb_projetof_scale;

  typedef struct packed {
    logic [15:0] pu;
    logic [15:0] pd;
    logic [15:0] ki;
    logic [15:0] kd;
    logic [15:0] ri;
    logic [15:0] rd;
  } out_t;

  typedef struct {
    logic [8:0]  c;
    logic [13:0] p;
    out_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [8:0]  centimos;
  logic [13:0] pesoemgramas;
  logic [15:0] Peso_Final_unidades;
  logic [15:0] Peso_Final_decimal;
  logic [15:0] Preco_Parte_Inteira;
  logic [15:0] Preco_Parte_Decimal;
  logic [15:0] Preco_Por_Kg_Parte_Inteira;
  logic [15:0] Preco_Por_Kg_Parte_Decimal;

  int pass_cnt  = 0;
  int check_cnt = 0;

  out_t exp_q[$];

  projetof_scale dut (
    .clk                        (clk),
    .rst                        (rst),
    .centimos                   (centimos),
    .pesoemgramas               (pesoemgramas),
    .Peso_Final_unidades        (Peso_Final_unidades),
    .Peso_Final_decimal         (Peso_Final_decimal),
    .Preco_Parte_Inteira        (Preco_Parte_Inteira),
    .Preco_Parte_Decimal        (Preco_Parte_Decimal),
    .Preco_Por_Kg_Parte_Inteira (Preco_Por_Kg_Parte_Inteira),
    .Preco_Por_Kg_Parte_Decimal (Preco_Por_Kg_Parte_Decimal)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model straight from the arithmetic definition
  function automatic out_t model(input int c, input int p);
    out_t o;
    int   tot;
    tot  = (c * p) / 1000;
    o.pu = 16'(p / 1000);
    o.pd = 16'(p % 1000);
    o.ki = 16'(c / 100);
    o.kd = 16'(c % 100);
    o.ri = 16'(tot / 100);
    o.rd = 16'(tot % 100);
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.pu = Peso_Final_unidades;
    o.pd = Peso_Final_decimal;
    o.ki = Preco_Por_Kg_Parte_Inteira;
    o.kd = Preco_Por_Kg_Parte_Decimal;
    o.ri = Preco_Parte_Inteira;
    o.rd = Preco_Parte_Decimal;
    return o;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    check_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic check_outs(input string tag, input out_t e);
    out_t a;
    a = sample();
    check({tag, ".peso_unid"}, a.pu, e.pu);
    check({tag, ".peso_dec"},  a.pd, e.pd);
    check({tag, ".kg_int"},    a.ki, e.ki);
    check({tag, ".kg_dec"},    a.kd, e.kd);
    check({tag, ".tot_int"},   a.ri, e.ri);
    check({tag, ".tot_dec"},   a.rd, e.rd);
  endtask

  // Driver: apply inputs, clock once, sample 1 time unit after the edge
  task automatic drive_and_step(input logic [8:0] c, input logic [13:0] p);
    centimos     = c;
    pesoemgramas = p;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];
  out_t zero_o;
  out_t prev_o;
  out_t exp_o;

  initial begin
    zero_o = '0;
    vecs[0] = '{9'd250, 14'd1500,  '{16'd1,  16'd500, 16'd2, 16'd50, 16'd3,  16'd75}};
    vecs[1] = '{9'd199, 14'd333,   '{16'd0,  16'd333, 16'd1, 16'd99, 16'd0,  16'd66}};
    vecs[2] = '{9'd511, 14'd16383, '{16'd16, 16'd383, 16'd5, 16'd11, 16'd83, 16'd71}};
    vecs[3] = '{9'd0,   14'd1000,  '{16'd1,  16'd0,   16'd0, 16'd0,  16'd0,  16'd0}};
    vecs[4] = '{9'd100, 14'd0,     '{16'd0,  16'd0,   16'd1, 16'd0,  16'd0,  16'd0}};
    vecs[5] = '{9'd123, 14'd999,   '{16'd0,  16'd999, 16'd1, 16'd23, 16'd1,  16'd22}};
    vecs[6] = '{9'd511, 14'd1000,  '{16'd1,  16'd0,   16'd5, 16'd11, 16'd5,  16'd11}};
    vecs[7] = '{9'd99,  14'd1001,  '{16'd1,  16'd1,   16'd0, 16'd99, 16'd0,  16'd99}};

    // Reset held for two edges with live inputs present
    rst          = 1'b1;
    centimos     = 9'd250;
    pesoemgramas = 14'd1500;
    @(posedge clk); #1;
    check_outs("reset1", zero_o);
    @(posedge clk); #1;
    check_outs("reset2", zero_o);
    rst = 1'b0;
    @(posedge clk); #1;
    check_outs("post_reset", vecs[0].e);

    // Directed table
    foreach (vecs[i]) begin
      drive_and_step(vecs[i].c, vecs[i].p);
      check_outs($sformatf("vec%0d", i), vecs[i].e);
    end

    // Back-to-back random sequence; outputs must hold until the next edge
    prev_o = vecs[7].e;
    for (int k = 0; k < 40; k++) begin
      logic [8:0]  c;
      logic [13:0] p;
      c = 9'($urandom_range(0, 511));
      p = 14'($urandom_range(0, 16383));
      centimos     = c;
      pesoemgramas = p;
      #1;
      check_outs($sformatf("hold%0d", k), prev_o);
      if (k == 20) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_outs("mid_reset", zero_o);
        rst = 1'b0;
      end
      exp_q.push_back(model(int'(c), int'(p)));
      @(posedge clk); #1;
      exp_o = exp_q.pop_front();
      check_outs($sformatf("seq%0d", k), exp_o);
      prev_o = exp_o;
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/projetof_scale.md
Name: projetof_scale

Overview:
- Price-computing scale datapath for the retail balance ("balança") design.
- Takes a price per kilogram in cents and a measured weight in grams.
- Produces registered, human-readable split values for display logic downstream:
  - weight as kg plus thousandths,
  - price per kg as euros plus cents,
  - total price as euros plus cents.

Parameters:
- None. All widths are fixed by the interface below.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- centimos  input  9  price per kg in cents, unsigned, 0..511
- pesoemgramas  input  14  weight in grams, unsigned, 0..16383
- Peso_Final_unidades  output  16  whole kilograms = pesoemgramas / 1000
- Peso_Final_decimal  output  16  gram remainder = pesoemgramas mod 1000 (0..999)
- Preco_Parte_Inteira  output  16  total price, whole euros
- Preco_Parte_Decimal  output  16  total price, cents part (0..99)
- Preco_Por_Kg_Parte_Inteira  output  16  price per kg, whole euros = centimos / 100
- Preco_Por_Kg_Parte_Decimal  output  16  price per kg, cents part = centimos mod 100

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - While rst=1 at a rising edge, all six outputs load 0.
  - rst has priority over input sampling.
- Latency and registering:
  - Outputs are registered, with a latency of 1 cycle.
  - Inputs present before rising edge N produce their results on the outputs immediately after edge N.
  - The outputs hold until the next edge.
  - Inputs are sampled every cycle. There is no handshake and no enable.
- Arithmetic (all values unsigned binary, not BCD):
  - total_cents = floor(centimos * pesoemgramas / 1000).
  - The full product needs 23 bits (max 511*16383 = 8,371,713). Intermediate products must not be truncated below 23 bits.
  - Preco_Parte_Inteira = total_cents / 100; Preco_Parte_Decimal = total_cents mod 100.
  - All divisions truncate toward zero. There is no rounding.
  - Peso and price-per-kg outputs are the quotient/remainder of the inputs by 1000 and 100 respectively.
- Output ranges and padding:
  - Peso_Final_unidades 0..16; Peso_Final_decimal 0..999.
  - Preco_Por_Kg_Parte_Inteira 0..5; Preco_Por_Kg_Parte_Decimal 0..99.
  - Preco_Parte_Inteira 0..83; Preco_Parte_Decimal 0..99.
  - Upper unused bits of every 16-bit output are 0.
- Boundary conditions:
  - Zero weight or zero price gives total 0.00. Weight and per-kg outputs still reflect the nonzero input.
  - No overflow or saturation is possible across the full input range.
  - If rst asserts mid-stream, the outputs are 0 on the next edge. The first cycle after rst deasserts reflects the inputs sampled at that edge.
- Implementation freedom:
  - Constant division may be combinational (multiply-by-reciprocal or subtract chains).
  - The 1-cycle latency is mandatory.
  - No latches. The only state is the output registers.

Test Plan:
- rst=1 for 2 cycles with centimos=250, pesoemgramas=1500 -> all outputs 0. Release rst -> next edge gives:
  - peso 1 / 500,
  - per-kg 2 / 50,
  - total 3 / 75 (375 cents).
- centimos=199, pesoemgramas=333 (truncation check, 66267/1000 = 66) ->
  - peso 0 / 333,
  - per-kg 1 / 99,
  - total 0 / 66.
- Max inputs centimos=511, pesoemgramas=16383 ->
  - peso 16 / 383,
  - per-kg 5 / 11,
  - total 83 / 71 (8371 cents),
  - no wrap.
- centimos=0, pesoemgramas=1000 -> peso 1 / 0, per-kg 0 / 0, total 0 / 0. Then centimos=100, pesoemgramas=0 -> per-kg 1 / 0, total 0 / 0.
- Latency check: change inputs every cycle through a random sequence -> each output set equals the reference model of the previous cycle's inputs.
- Assert rst for one cycle in the middle of that sequence -> outputs are 0 for exactly that cycle, then the sequence resumes.
